// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: 2-FF synchroniser, tick-sampled debounce, and
// press/release/long-hold/auto-repeat pulse generation. All outputs registered.
module btn_debounce_pulse #(
    parameter int unsigned SAMPLE_DIV   = 1_000_000,
    parameter int unsigned STABLE_CNT   = 4,
    parameter int unsigned LONG_TICKS   = 100,
    parameter int unsigned REPEAT_TICKS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic long_hold
);

    localparam int unsigned DIV_W    = $clog2(SAMPLE_DIV + 1);
    localparam int unsigned STB_W    = $clog2(STABLE_CNT + 1);
    localparam int unsigned HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int unsigned HLD_W    = $clog2(HOLD_MAX + 1);

    localparam logic [1:0] S_RELEASED = 2'd0;
    localparam logic [1:0] S_PRESSED  = 2'd1;
    localparam logic [1:0] S_HELD     = 2'd2;

    logic             sync1_q, sync2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [STB_W-1:0] stb_q, stb_d, stb_inc;
    logic [HLD_W-1:0] hold_q, hold_d, hold_inc;
    logic [1:0]       state_q, state_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;
    logic             long_q, long_d;
    logic             tick, flip;

    always_comb begin
        tick    = (div_q == DIV_W'(SAMPLE_DIV - 1));
        div_d   = tick ? '0 : div_q + DIV_W'(1);

        stb_inc = stb_q + STB_W'(1);
        stb_d   = stb_q;
        level_d = level_q;
        flip    = 1'b0;
        if (tick) begin
            if (sync2_q != level_q) begin
                if (stb_inc == STB_W'(STABLE_CNT)) begin
                    flip    = 1'b1;
                    level_d = ~level_q;
                    stb_d   = '0;
                end else begin
                    stb_d = stb_inc;
                end
            end else begin
                stb_d = '0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        hold_inc  = hold_q + HLD_W'(1);
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            S_RELEASED: begin
                if (flip && !level_q) begin
                    state_d = S_PRESSED;
                    press_d = 1'b1;
                    hold_d  = '0;
                end
            end
            S_PRESSED, S_HELD: begin
                // A release flip wins over the hold increment on the same tick.
                if (flip && level_q) begin
                    state_d   = S_RELEASED;
                    release_d = 1'b1;
                    hold_d    = '0;
                end else if (tick) begin
                    if (state_q == S_PRESSED && hold_inc == HLD_W'(LONG_TICKS)) begin
                        state_d  = S_HELD;
                        repeat_d = 1'b1;
                        hold_d   = '0;
                    end else if (state_q == S_HELD && hold_inc == HLD_W'(REPEAT_TICKS)) begin
                        repeat_d = 1'b1;
                        hold_d   = '0;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
            end
            default: begin
                state_d = S_RELEASED;
                hold_d  = '0;
            end
        endcase
        long_d = (state_d == S_HELD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            div_q     <= '0;
            stb_q     <= '0;
            hold_q    <= '0;
            state_q   <= S_RELEASED;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= btn_in;
            sync2_q   <= sync1_q;
            div_q     <= div_d;
            stb_q     <= stb_d;
            hold_q    <= hold_d;
            state_q   <= state_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            long_q    <= long_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    assign long_hold     = long_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench for btn_debounce_pulse: stimulus pushes expected pulse events
// (kind, edge index since reset, level, long_hold); a negedge monitor pops and compares.
module tb_btn_debounce_pulse;

    localparam int unsigned DIV = 4;
    localparam int unsigned STB = 3;
    localparam int unsigned LNG = 8;
    localparam int unsigned REP = 2;

    localparam logic [2:0] P_PRESS = 3'b100;
    localparam logic [2:0] P_REL   = 3'b010;
    localparam logic [2:0] P_REP   = 3'b001;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_in;
    logic btn_level, press_pulse, release_pulse, repeat_pulse, long_hold;

    btn_debounce_pulse #(
        .SAMPLE_DIV  (DIV),
        .STABLE_CNT  (STB),
        .LONG_TICKS  (LNG),
        .REPEAT_TICKS(REP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .long_hold    (long_hold)
    );

    always #5 clk = ~clk;

    // Edges since reset release; sample ticks land on multiples of DIV.
    int unsigned ecount = 0;
    always @(posedge clk) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    typedef struct {
        logic [2:0]  pulses;
        int unsigned cyc;
        logic        level;
        logic        hold;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input bit ok, input string msg);
        n_total++;
        if (ok) n_pass++;
        else    $display("FAIL %s", msg);
    endtask

    task automatic expect_ev(input logic [2:0] p, input int unsigned c);
        exp_t e;
        e.pulses = p;
        e.cyc    = c;
        e.level  = (p != P_REL);
        e.hold   = (p == P_REP);
        sb.push_back(e);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            while (ecount % DIV != 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    logic [2:0] obs;
    exp_t       e_mon;
    always @(negedge clk) begin
        obs = {press_pulse, release_pulse, repeat_pulse};
        if (rst_n && obs != 3'b000) begin
            if (sb.size() == 0) begin
                chk(1'b0, $sformatf("unexpected_pulse got pulses=%b cyc=%0d level=%b hold=%b, required no pulse",
                                    obs, ecount, btn_level, long_hold));
            end else begin
                e_mon = sb.pop_front();
                chk(obs == e_mon.pulses && ecount == e_mon.cyc &&
                    btn_level == e_mon.level && long_hold == e_mon.hold,
                    $sformatf("pulse_event got pulses=%b cyc=%0d level=%b hold=%b, required pulses=%b cyc=%0d level=%b hold=%b",
                              obs, ecount, btn_level, long_hold,
                              e_mon.pulses, e_mon.cyc, e_mon.level, e_mon.hold));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout, required finish");
        $fatal(1, "watchdog");
    end

    int unsigned t0;

    initial begin
        rst_n  = 1'b0;
        btn_in = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk({btn_level, press_pulse, release_pulse, repeat_pulse, long_hold} == 5'b0,
                $sformatf("reset_outputs got %b, required 00000",
                          {btn_level, press_pulse, release_pulse, repeat_pulse, long_hold}));
        end
        rst_n  = 1'b1;
        btn_in = 1'b0;
        wait_ticks(2);

        // clean press then release
        t0 = ecount;
        expect_ev(P_PRESS, t0 + 12);
        btn_in = 1'b1;
        wait_ticks(4);
        t0 = ecount;
        expect_ev(P_REL, t0 + 12);
        btn_in = 1'b0;
        wait_ticks(5);

        // bounce: toggle every tick, never three agreeing samples
        for (int i = 0; i < 6; i++) begin
            btn_in = (i % 2 == 0);
            wait_ticks(1);
        end
        btn_in = 1'b0;
        wait_ticks(4);
        chk(btn_level == 1'b0, $sformatf("bounce_level got %b, required 0", btn_level));

        // short glitch: two high samples then low
        btn_in = 1'b1;
        wait_ticks(2);
        btn_in = 1'b0;
        wait_ticks(2);
        chk(btn_level == 1'b0, $sformatf("glitch_level got %b, required 0", btn_level));

        // long hold; full 3-tick press latency also proves the glitch credit was cleared
        t0 = ecount;
        expect_ev(P_PRESS, t0 + 12);
        expect_ev(P_REP,   t0 + 44);
        expect_ev(P_REP,   t0 + 52);
        expect_ev(P_REP,   t0 + 60);
        expect_ev(P_REP,   t0 + 68);
        expect_ev(P_REL,   t0 + 76);
        btn_in = 1'b1;
        wait_ticks(16);
        btn_in = 1'b0;
        wait_ticks(5);
        chk(long_hold == 1'b0 && btn_level == 1'b0,
            $sformatf("after_release got level=%b hold=%b, required level=0 hold=0", btn_level, long_hold));
        wait_ticks(3);

        // reset while held
        t0 = ecount;
        expect_ev(P_PRESS, t0 + 12);
        expect_ev(P_REP,   t0 + 44);
        btn_in = 1'b1;
        wait_ticks(12);
        chk(long_hold == 1'b1, $sformatf("held_before_reset got hold=%b, required 1", long_hold));
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk({btn_level, press_pulse, release_pulse, repeat_pulse, long_hold} == 5'b0,
            $sformatf("midhold_reset got %b, required 00000",
                      {btn_level, press_pulse, release_pulse, repeat_pulse, long_hold}));
        rst_n = 1'b1;
        expect_ev(P_PRESS, 12);
        expect_ev(P_REP,   44);
        wait_ticks(11);
        expect_ev(P_REP,   52);
        expect_ev(P_REL,   56);
        btn_in = 1'b0;
        wait_ticks(5);

        chk(sb.size() == 0, $sformatf("scoreboard_drain got %0d pending, required 0", sb.size()));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
